// File: rtl/md_div_sched_pkg.sv
// Shared types, constants and helpers for the dual-lane divide scheduler.
package md_div_sched_pkg;

  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic LANE1 = 1'b0;
  localparam logic LANE2 = 1'b1;

  typedef struct packed {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
  } div_op_t;

  // Absolute value when the operation is signed; raw operand otherwise.
  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_div_sched_if.sv
// Issue-side request lanes and result/stall bundle of the divide scheduler.
interface md_div_sched_if;
  logic        flush;
  logic        req_i1;
  logic        signed_i1;
  logic [31:0] opa_i1;
  logic [31:0] opb_i1;
  logic        req_i2;
  logic        signed_i2;
  logic [31:0] opa_i2;
  logic [31:0] opb_i2;
  logic        stallreq_for_div;
  logic        res_valid;
  logic        res_lane;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  modport master (
    output flush, req_i1, signed_i1, opa_i1, opb_i1,
    output req_i2, signed_i2, opa_i2, opb_i2,
    input  stallreq_for_div, res_valid, res_lane, res_hi, res_lo
  );

  modport slave (
    input  flush, req_i1, signed_i1, opa_i1, opb_i1,
    input  req_i2, signed_i2, opa_i2, opb_i2,
    output stallreq_for_div, res_valid, res_lane, res_hi, res_lo
  );
endinterface

// File: rtl/md_div_sched_div_core.sv
// Restoring shift-subtract divider on 32-bit magnitudes, DIV_CYCLES steps after start.
// done is high during the final step; quo/rem carry that step's result, no backpressure.
module div_core
  import md_div_sched_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   quo_r;
  logic [31:0]   rem_r;
  logic [31:0]   dvs_r;
  logic [32:0]   rem_sh;
  logic          ge;

  // A zero divisor always subtracts, giving an all-ones quotient and rem = dividend.
  always_comb begin
    rem_sh = {rem_r, quo_r[31]};
    ge     = rem_sh >= {1'b0, dvs_r};
    quo    = {quo_r[30:0], ge};
    rem    = ge ? (rem_sh[31:0] - dvs_r) : rem_sh[31:0];
  end

  assign done = busy && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy  <= 1'b0;
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dvs_r <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(DIV_CYCLES);
      quo_r <= dividend;
      rem_r <= '0;
      dvs_r <= divisor;
    end else if (busy) begin
      quo_r <= quo;
      rem_r <= rem;
      cnt   <= cnt - CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/md_div_sched.sv
// Two-lane divide scheduler: lane 1 wins, a simultaneous lane-2 request is queued behind it.
// Result strobes DIV_CYCLES+1 cycles after accept; stallreq_for_div holds issue meanwhile.
module md_div_sched
  import md_div_sched_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic         clk,
  input logic         rst,
  md_div_sched_if.slave bus
);

  state_t      state;
  logic        pend;
  div_op_t     pend_op;
  logic        cur_lane;
  logic        cur_neg_q;
  logic        cur_neg_r;
  logic        res_valid_q;
  logic        res_lane_q;
  logic [31:0] res_hi_q;
  logic [31:0] res_lo_q;

  div_op_t     op1;
  div_op_t     op2;
  div_op_t     op_sel;
  logic        accept;
  logic        relaunch;
  logic        launch;
  logic        lane_sel;

  logic        core_busy;
  logic        core_done;
  logic [31:0] core_quo;
  logic [31:0] core_rem;

  always_comb begin
    op1      = '{sgn: bus.signed_i1, a: bus.opa_i1, b: bus.opb_i1};
    op2      = '{sgn: bus.signed_i2, a: bus.opa_i2, b: bus.opb_i2};
    accept   = !rst && (state == ST_IDLE) && (bus.req_i1 || bus.req_i2) && !bus.flush;
    relaunch = !rst && (state == ST_DONE) && pend && !bus.flush;
    launch   = accept || relaunch;
    op_sel   = relaunch ? pend_op : (bus.req_i1 ? op1 : op2);
    lane_sel = relaunch ? LANE2 : (bus.req_i1 ? LANE1 : LANE2);
  end

  div_core #(.DIV_CYCLES(DIV_CYCLES)) u_core (
    .clk      (clk),
    .rst      (rst),
    .abort    (bus.flush),
    .start    (launch),
    .dividend (mag(op_sel.sgn, op_sel.a)),
    .divisor  (mag(op_sel.sgn, op_sel.b)),
    .busy     (core_busy),
    .done     (core_done),
    .quo      (core_quo),
    .rem      (core_rem)
  );

  assign bus.stallreq_for_div = accept || core_busy || ((state == ST_DONE) && pend);
  assign bus.res_valid        = res_valid_q;
  assign bus.res_lane         = res_lane_q;
  assign bus.res_hi           = res_hi_q;
  assign bus.res_lo           = res_lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pend        <= 1'b0;
      pend_op     <= '0;
      cur_lane    <= LANE1;
      cur_neg_q   <= 1'b0;
      cur_neg_r   <= 1'b0;
      res_valid_q <= 1'b0;
      res_lane_q  <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
    end else begin
      res_valid_q <= 1'b0;
      res_lane_q  <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      if (launch) begin
        cur_lane  <= lane_sel;
        // Divide-by-zero keeps the raw all-ones quotient regardless of sign.
        cur_neg_q <= op_sel.sgn && (op_sel.a[31] ^ op_sel.b[31]) && (op_sel.b != 32'd0);
        cur_neg_r <= op_sel.sgn && op_sel.a[31];
      end
      if (bus.flush) begin
        state <= ST_IDLE;
        pend  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (accept) begin
            state   <= ST_CALC;
            pend    <= bus.req_i1 && bus.req_i2;
            pend_op <= op2;
          end
          ST_CALC: if (core_done) begin
            state       <= ST_DONE;
            res_valid_q <= 1'b1;
            res_lane_q  <= cur_lane;
            res_lo_q    <= cur_neg_q ? (32'd0 - core_quo) : core_quo;
            res_hi_q    <= cur_neg_r ? (32'd0 - core_rem) : core_rem;
          end
          ST_DONE: begin
            pend  <= 1'b0;
            state <= pend ? ST_CALC : ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_div_sched.sv
// Directed bench for md_div_sched: latency, lane arbitration, sign fix-up, flush and reset.
module tb_md_div_sched
  import md_div_sched_pkg::*;
;

  logic clk = 1'b0;
  logic rst = 1'b1;

  md_div_sched_if bus();

  md_div_sched #(.DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.req_i1 = 1'b0;
    bus.req_i2 = 1'b0;
  endtask

  task automatic set_l1(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.req_i1 = 1'b1; bus.signed_i1 = s; bus.opa_i1 = a; bus.opb_i1 = b;
  endtask

  task automatic set_l2(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.req_i2 = 1'b1; bus.signed_i2 = s; bus.opa_i2 = a; bus.opb_i2 = b;
  endtask

  // Cycles from the current cycle to the next strobe (0 on timeout); stall must hold until then.
  task automatic wait_res(output int c, output logic stall_ok);
    stall_ok = 1'b1;
    c = 0;
    for (int i = 1; i <= 200; i++) begin
      cyc();
      if (i == 1) clear_req();
      #1;
      if (bus.res_valid) begin
        c = i;
        break;
      end
      if (!bus.stallreq_for_div) stall_ok = 1'b0;
    end
  endtask

  task automatic quiet(input int n, output logic q);
    q = 1'b1;
    repeat (n) begin
      cyc();
      #1;
      if (bus.res_valid) q = 1'b0;
    end
  endtask

  task automatic chk_res(input string tag, input int c, input logic stall_ok,
                         input logic lane, input logic [31:0] lo, input logic [31:0] hi);
    chk({tag, "_latency"}, 32'(c), 32'd33);
    chk({tag, "_stall_held"}, 32'(stall_ok), 32'd1);
    chk({tag, "_lane"}, 32'(bus.res_lane), 32'(lane));
    chk({tag, "_lo"}, bus.res_lo, lo);
    chk({tag, "_hi"}, bus.res_hi, hi);
  endtask

  task automatic run_one(input string tag, input logic lane, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi);
    int   c;
    logic ok;
    cyc();
    if (lane == LANE1) set_l1(s, a, b);
    else               set_l2(s, a, b);
    #1;
    chk({tag, "_stall_accept"}, 32'(bus.stallreq_for_div), 32'd1);
    wait_res(c, ok);
    chk_res(tag, c, ok, lane, lo, hi);
    chk({tag, "_stall_final"}, 32'(bus.stallreq_for_div), 32'd0);
  endtask

  initial begin
    int   c;
    logic ok;
    logic q;

    bus.flush = 1'b0;
    clear_req();
    bus.signed_i1 = 1'b0; bus.opa_i1 = '0; bus.opb_i1 = '0;
    bus.signed_i2 = 1'b0; bus.opa_i2 = '0; bus.opb_i2 = '0;
    rst = 1'b1;
    cyc();
    cyc();
    #1;
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_stall", 32'(bus.stallreq_for_div), 32'd0);
    chk("rst_lane", 32'(bus.res_lane), 32'd0);
    chk("rst_lo", bus.res_lo, 32'd0);
    chk("rst_hi", bus.res_hi, 32'd0);
    rst = 1'b0;

    run_one("udiv", LANE1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    cyc();
    #1;
    chk("udiv_strobe_one_cycle", 32'(bus.res_valid), 32'd0);
    chk("udiv_lo_cleared", bus.res_lo, 32'd0);
    chk("udiv_hi_cleared", bus.res_hi, 32'd0);

    run_one("sdiv_l2", LANE2, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_one("sdiv_negb", LANE1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);

    // Both lanes in the same cycle: lane 1 first, lane 2 replayed straight after.
    cyc();
    set_l1(1'b0, 32'd20, 32'd3);
    set_l2(1'b0, 32'd9, 32'd4);
    #1;
    chk("dual_stall_accept", 32'(bus.stallreq_for_div), 32'd1);
    wait_res(c, ok);
    chk_res("dual_first", c, ok, LANE1, 32'd6, 32'd2);
    chk("dual_stall_mid_done", 32'(bus.stallreq_for_div), 32'd1);
    wait_res(c, ok);
    chk_res("dual_second", c, ok, LANE2, 32'd2, 32'd1);
    chk("dual_stall_final", 32'(bus.stallreq_for_div), 32'd0);

    // Flush at T+10 of an in-flight divide, then a fresh request at T+12.
    cyc();
    set_l1(1'b0, 32'd50, 32'd5);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i == 1) clear_req();
    end
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    #1;
    chk("flush_stall_low", 32'(bus.stallreq_for_div), 32'd0);
    chk("flush_no_valid", 32'(bus.res_valid), 32'd0);
    cyc();
    set_l1(1'b0, 32'd81, 32'd9);
    #1;
    wait_res(c, ok);
    chk_res("after_flush", c, ok, LANE1, 32'd9, 32'd0);

    // Flush coinciding with the request suppresses acceptance.
    cyc();
    set_l1(1'b0, 32'd30, 32'd3);
    bus.flush = 1'b1;
    #1;
    chk("flush_accept_stall", 32'(bus.stallreq_for_div), 32'd0);
    cyc();
    bus.flush = 1'b0;
    clear_req();
    #1;
    chk("flush_accept_idle_stall", 32'(bus.stallreq_for_div), 32'd0);
    quiet(40, q);
    chk("flush_accept_no_result", 32'(q), 32'd1);

    run_one("udiv_zero", LANE1, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    run_one("sdiv_zero", LANE2, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Reset at T+5 of a divide discards it.
    cyc();
    set_l1(1'b0, 32'd1000, 32'd10);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 1) clear_req();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.res_valid), 32'd0);
    chk("midrst_stall", 32'(bus.stallreq_for_div), 32'd0);
    chk("midrst_lane", 32'(bus.res_lane), 32'd0);
    chk("midrst_lo", bus.res_lo, 32'd0);
    chk("midrst_hi", bus.res_hi, 32'd0);
    quiet(40, q);
    chk("midrst_no_result", 32'(q), 32'd1);

    run_one("sdiv_ovf", LANE1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
